fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the main control decoder in the MIPS-style processor. It holds the PC and requests instructions from instruction memory over a req/ack handshake. It latches each returned instruction and presents instr/opcode to the decoder and datapath for one execute window. At the end of each execute window it computes the next PC from the decoder's branch/jump outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 2'b00.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address (equals pc)
imem_ack  input  1  memory response valid; sampled only in REQ
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr  output  32  latched instruction for the datapath
opcode  output  6  instr[31:26], drives the control decoder
instr_valid  output  1  instr/opcode are live this cycle (EXEC state)
pc  output  32  address of the current instruction
branch  input  1  Branch1 from the control decoder
alu_zero  input  1  ALU zero flag for the current instruction
jump  input  1  jump from the control decoder
stall  input  1  hold the current instruction in EXEC
retired  output  32  count of completed instructions

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- On reset: state=IDLE, pc=RESET_PC, instr=0, retired=0. Outputs imem_req=0 and instr_valid=0.
- opcode resets to 0, which decodes as R-type. The datapath must gate RegWrite/MemWrite with instr_valid.
- FSM states: IDLE, REQ, EXEC.
- IDLE: always moves to REQ on the next cycle. imem_req=0.
- REQ:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - If imem_ack=1 (including in the first REQ cycle): instr<=imem_rdata and state->EXEC.
  - Otherwise remain in REQ.
  - instr_valid=0.
- EXEC:
  - instr_valid=1 and imem_req=0. The decoder and datapath evaluate combinationally from instr.
  - If stall=1: remain in EXEC with pc, instr and retired unchanged.
  - If stall=0: pc<=next_pc, retired<=retired+1, state->REQ.
- next_pc (computed only in EXEC), with pc_plus4 = pc+4 mod 2^32:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - Else branch=1 and alu_zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), mod 2^32.
  - Else: pc_plus4.
- Wrap-around: all PC arithmetic wraps silently; no exception.
- retired wraps from 32'hFFFF_FFFF to 0.
- imem_ack outside REQ is ignored; no capture and no state change.
- branch, jump and alu_zero outside EXEC are ignored.
- Latency: minimum 2 cycles per instruction (REQ with same-cycle ack, then EXEC). Each extra ack-wait or stall cycle adds one.
- Reset mid-operation (any state, including waiting for ack or stalled): next cycle state=IDLE, pc=RESET_PC, retired=0, imem_req=0. An imem_ack arriving in the reset cycle is discarded.
- pc[1:0] is always 2'b00.

Test Plan:
1. Reset with RESET_PC=0, release; ack at once with 32'h8C01_0004 → cycle 1 IDLE (req=0); cycle 2 req=1, addr=0; cycle 3 instr_valid=1, opcode=6'h23; cycle 4 addr=32'h4, retired=1.
2. Hold imem_ack low for 3 cycles in REQ → imem_req stays 1, imem_addr stable, instr_valid stays 0, instr unchanged; ack on cycle 4 → EXEC the next cycle.
3. pc=32'h10, instr=32'h1000_FFFF, branch=1:
   - alu_zero=1 → next fetch addr 32'h10.
   - alu_zero=0 → next fetch addr 32'h14.
4. pc=32'h4000_0000, instr=32'h0800_0010, jump=1 → next addr 32'h4000_0040. Repeat with branch=1 and alu_zero=1 also set → still 32'h4000_0040.
5. stall=1 for 2 EXEC cycles → instr_valid held for 3 cycles total, pc unchanged, retired increments by exactly 1 after stall drops.
6. RESET_PC=32'hFFFF_FFFC, sequential instruction → next addr 32'h0000_0000. Then assert reset while in REQ with ack=1 → next cycle IDLE, req=0, pc=RESET_PC, retired=0, instr not updated.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch handshake between the fetch stage and imem.
//   master: fetch side, drives imem_req/imem_addr, receives imem_ack/imem_rdata
//   slave : memory side, the mirror image
interface fetch_unit_if;
  logic        imem_req;   // fetch request, held until acknowledged
  logic [31:0] imem_addr;  // word-aligned fetch address
  logic        imem_ack;   // response valid this cycle
  logic [31:0] imem_rdata; // instruction word, valid with imem_ack

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC, fetches over req/ack, presents instr to decode, computes next PC.
// Latency: 2 cycles per instruction minimum (REQ with same-cycle ack, EXEC); +1 per ack-wait or stall cycle.
// Backpressure: imem_req held with stable address until imem_ack; stall holds the instruction in EXEC.
// Ports: clk/reset (sync, active-high); imem (fetch_unit_if.master); instr/opcode/instr_valid/pc to the
//        datapath; branch/alu_zero/jump/stall from decoder and ALU; retired = completed instruction count.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr,
  output logic [5:0]          opcode,
  output logic                instr_valid,
  output logic [31:0]         pc,
  input  logic                branch,
  input  logic                alu_zero,
  input  logic                jump,
  input  logic                stall,
  output logic [31:0]         retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        capture;   // latch imem_rdata this cycle
  logic        advance;   // retire current instruction and move pc
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] next_pc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem.imem_ack) state_nxt = EXEC;
      EXEC:    if (!stall)        state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. imem_ack is only looked at in REQ, so a stray ack in
  // IDLE/EXEC cannot overwrite the instruction being executed.
  always_comb begin
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    capture       = 1'b0;
    advance       = 1'b0;
    case (state)
      REQ: begin
        imem.imem_req = 1'b1;
        capture       = imem.imem_ack;
      end
      EXEC: begin
        instr_valid = 1'b1;
        advance     = !stall;
      end
      default: ;
    endcase
  end

  assign imem.imem_addr = pc;
  assign opcode         = instr[31:26];

  // Next-PC selection; jump wins over a taken branch. All arithmetic wraps mod 2^32.
  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch && alu_zero) begin
      next_pc = pc_plus4 + br_offset;
    end
  end

  // Architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr   <= 32'h0000_0000;
      retired <= 32'h0000_0000;
    end else begin
      if (capture) begin
        instr <= imem.imem_rdata;
      end
      if (advance) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three instances with different RESET_PC values share the
// memory/decoder stimulus; only the one under test is out of reset at a time.
// Expected fetch addresses are queued when each instruction is executed and
// popped when the DUT next raises imem_req.
module tb_fetch_unit;

  logic        clk;
  logic        rst [3];
  logic        ack;
  logic [31:0] rdata;
  logic        branch, jump, alu_zero, stall;

  logic        req_o   [3];
  logic [31:0] addr_o  [3];
  logic [31:0] instr_o [3];
  logic [5:0]  opc_o   [3];
  logic        vld_o   [3];
  logic [31:0] pc_o    [3];
  logic [31:0] ret_o   [3];

  int          nvec;
  int          nerr;
  logic [31:0] exp_q [$];
  logic [31:0] exp_ret  [3];
  logic [31:0] last_word[3];

  fetch_unit_if ifa ();
  fetch_unit_if ifb ();
  fetch_unit_if ifc ();

  assign ifa.imem_ack = ack;  assign ifa.imem_rdata = rdata;
  assign ifb.imem_ack = ack;  assign ifb.imem_rdata = rdata;
  assign ifc.imem_ack = ack;  assign ifc.imem_rdata = rdata;

  assign req_o[0] = ifa.imem_req;  assign addr_o[0] = ifa.imem_addr;
  assign req_o[1] = ifb.imem_req;  assign addr_o[1] = ifb.imem_addr;
  assign req_o[2] = ifc.imem_req;  assign addr_o[2] = ifc.imem_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .reset(rst[0]), .imem(ifa),
    .instr(instr_o[0]), .opcode(opc_o[0]), .instr_valid(vld_o[0]), .pc(pc_o[0]),
    .branch(branch), .alu_zero(alu_zero), .jump(jump), .stall(stall), .retired(ret_o[0])
  );

  fetch_unit #(.RESET_PC(32'h4000_0000)) dut_b (
    .clk(clk), .reset(rst[1]), .imem(ifb),
    .instr(instr_o[1]), .opcode(opc_o[1]), .instr_valid(vld_o[1]), .pc(pc_o[1]),
    .branch(branch), .alu_zero(alu_zero), .jump(jump), .stall(stall), .retired(ret_o[1])
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_c (
    .clk(clk), .reset(rst[2]), .imem(ifc),
    .instr(instr_o[2]), .opcode(opc_o[2]), .instr_valid(vld_o[2]), .pc(pc_o[2]),
    .branch(branch), .alu_zero(alu_zero), .jump(jump), .stall(stall), .retired(ret_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Reset one instance and check the first cycle after release (state IDLE).
  task automatic test_reset(input int d, input logic [31:0] rpc);
    rst[d] = 1'b1; ack = 1'b0; rdata = $urandom;
    branch = 1'b0; jump = 1'b0; alu_zero = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    rst[d] = 1'b0;
    exp_q.delete();
    exp_q.push_back(rpc);
    exp_ret[d]   = 32'd0;
    last_word[d] = 32'd0;
    #1;
    nvec++; if (req_o[d] !== 1'b0)     begin nerr++; $display("FAIL reset_req[%0d]: got %b want 0", d, req_o[d]); end
    nvec++; if (vld_o[d] !== 1'b0)     begin nerr++; $display("FAIL reset_vld[%0d]: got %b want 0", d, vld_o[d]); end
    nvec++; if (pc_o[d] !== rpc)       begin nerr++; $display("FAIL reset_pc[%0d]: got %h want %h", d, pc_o[d], rpc); end
    nvec++; if (instr_o[d] !== 32'd0)  begin nerr++; $display("FAIL reset_instr[%0d]: got %h want 0", d, instr_o[d]); end
    nvec++; if (opc_o[d] !== 6'd0)     begin nerr++; $display("FAIL reset_opcode[%0d]: got %h want 0", d, opc_o[d]); end
    nvec++; if (ret_o[d] !== 32'd0)    begin nerr++; $display("FAIL reset_retired[%0d]: got %h want 0", d, ret_o[d]); end
  endtask

  // One instruction: wait for the request, optionally delay the ack, execute
  // with the given decoder inputs and stall count, then check the retirement.
  task automatic fetch(input int d, input logic [31:0] word, input logic b, input logic j,
                       input logic z, input int waits, input int stalls);
    int          n;
    logic [31:0] cur, p4, nxt;
    n = 0;
    while (req_o[d] !== 1'b1 && n < 8) begin
      @(negedge clk); n++;
    end
    nvec++;
    if (req_o[d] !== 1'b1) begin
      nerr++; $display("FAIL req_timeout[%0d]: imem_req got %b want 1 within 8 cycles", d, req_o[d]);
      return;
    end
    if (exp_q.size() == 0) begin
      nvec++; nerr++; $display("FAIL scoreboard_empty[%0d]: request at %h with no expected address", d, addr_o[d]);
      return;
    end
    cur = exp_q.pop_front();
    nvec++; if (addr_o[d] !== cur) begin nerr++; $display("FAIL fetch_addr[%0d]: got %h want %h", d, addr_o[d], cur); end
    nvec++; if (vld_o[d] !== 1'b0) begin nerr++; $display("FAIL req_vld[%0d]: got %b want 0", d, vld_o[d]); end

    for (int w = 0; w < waits; w++) begin
      ack = 1'b0; rdata = $urandom;
      @(negedge clk);
      nvec++; if (req_o[d] !== 1'b1)          begin nerr++; $display("FAIL wait_req[%0d]: got %b want 1", d, req_o[d]); end
      nvec++; if (addr_o[d] !== cur)          begin nerr++; $display("FAIL wait_addr[%0d]: got %h want %h", d, addr_o[d], cur); end
      nvec++; if (vld_o[d] !== 1'b0)          begin nerr++; $display("FAIL wait_vld[%0d]: got %b want 0", d, vld_o[d]); end
      nvec++; if (instr_o[d] !== last_word[d]) begin nerr++; $display("FAIL wait_instr[%0d]: got %h want %h", d, instr_o[d], last_word[d]); end
    end

    ack = 1'b1; rdata = word;
    @(negedge clk);
    last_word[d] = word;
    // EXEC: stray ack with a different word must be ignored while stalled.
    ack   = (stalls > 0);
    rdata = ~word;
    nvec++; if (vld_o[d] !== 1'b1)           begin nerr++; $display("FAIL exec_vld[%0d]: got %b want 1", d, vld_o[d]); end
    nvec++; if (req_o[d] !== 1'b0)           begin nerr++; $display("FAIL exec_req[%0d]: got %b want 0", d, req_o[d]); end
    nvec++; if (instr_o[d] !== word)         begin nerr++; $display("FAIL exec_instr[%0d]: got %h want %h", d, instr_o[d], word); end
    nvec++; if (opc_o[d] !== word[31:26])    begin nerr++; $display("FAIL exec_opcode[%0d]: got %h want %h", d, opc_o[d], word[31:26]); end
    branch = b; jump = j; alu_zero = z; stall = (stalls > 0);

    for (int s = 0; s < stalls; s++) begin
      @(negedge clk);
      nvec++; if (vld_o[d] !== 1'b1)       begin nerr++; $display("FAIL stall_vld[%0d]: got %b want 1", d, vld_o[d]); end
      nvec++; if (pc_o[d] !== cur)         begin nerr++; $display("FAIL stall_pc[%0d]: got %h want %h", d, pc_o[d], cur); end
      nvec++; if (instr_o[d] !== word)     begin nerr++; $display("FAIL stall_instr[%0d]: got %h want %h", d, instr_o[d], word); end
      nvec++; if (ret_o[d] !== exp_ret[d]) begin nerr++; $display("FAIL stall_retired[%0d]: got %h want %h", d, ret_o[d], exp_ret[d]); end
      if (s == stalls - 1) begin
        stall = 1'b0; ack = 1'b0;
      end
    end

    p4 = cur + 32'd4;
    if (j)           nxt = {p4[31:28], word[25:0], 2'b00};
    else if (b && z) nxt = p4 + {{14{word[15]}}, word[15:0], 2'b00};
    else             nxt = p4;
    exp_ret[d] = exp_ret[d] + 32'd1;

    @(negedge clk);
    nvec++; if (vld_o[d] !== 1'b0)       begin nerr++; $display("FAIL post_vld[%0d]: got %b want 0", d, vld_o[d]); end
    nvec++; if (pc_o[d] !== nxt)         begin nerr++; $display("FAIL next_pc[%0d]: got %h want %h", d, pc_o[d], nxt); end
    nvec++; if (ret_o[d] !== exp_ret[d]) begin nerr++; $display("FAIL retired[%0d]: got %h want %h", d, ret_o[d], exp_ret[d]); end
    exp_q.push_back(nxt);
    // Decoder outputs outside EXEC must have no effect.
    branch = 1'b1; jump = 1'b1; alu_zero = 1'b1; ack = 1'b0; rdata = $urandom;
  endtask

  task automatic test_first_fetch();
    test_reset(0, 32'h0000_0000);
    @(negedge clk);
    nvec++; if (req_o[0] !== 1'b1)        begin nerr++; $display("FAIL c2_req: got %b want 1", req_o[0]); end
    nvec++; if (addr_o[0] !== 32'h0)      begin nerr++; $display("FAIL c2_addr: got %h want 0", addr_o[0]); end
    fetch(0, 32'h8C01_0004, 1'b0, 1'b0, 1'b0, 0, 0);
    nvec++; if (addr_o[0] !== 32'h4)      begin nerr++; $display("FAIL c4_addr: got %h want 4", addr_o[0]); end
  endtask

  task automatic test_ack_wait();
    fetch(0, 32'h2002_0001, 1'b0, 1'b0, 1'b0, 3, 0);
  endtask

  task automatic test_branch();
    fetch(0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0);  // pc 8 -> c
    fetch(0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1, 0);  // pc c -> 10
    fetch(0, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1, 0, 0);  // taken, back to 10
    fetch(0, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 0, 0);  // not taken, 14
    fetch(0, 32'h1000_0003, 1'b1, 1'b0, 1'b1, 0, 0);  // forward, 24
  endtask

  task automatic test_stall();
    fetch(0, 32'h0043_2020, 1'b0, 1'b0, 1'b0, 0, 2);
    fetch(0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2, 1);
  endtask

  task automatic test_jump();
    rst[0] = 1'b1;
    test_reset(1, 32'h4000_0000);
    fetch(1, 32'h0800_0010, 1'b0, 1'b1, 1'b0, 0, 0);
    fetch(1, 32'h0800_0010, 1'b1, 1'b1, 1'b1, 0, 0);
    fetch(1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_wrap_and_reset();
    rst[1] = 1'b1;
    test_reset(2, 32'hFFFF_FFFC);
    fetch(2, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0);
    // Now in REQ at pc 0: reset with an ack present in the same cycle.
    nvec++; if (req_o[2] !== 1'b1) begin nerr++; $display("FAIL wrap_req: got %b want 1", req_o[2]); end
    rst[2] = 1'b1; ack = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst[2] = 1'b0; ack = 1'b0;
    nvec++; if (req_o[2] !== 1'b0)           begin nerr++; $display("FAIL mid_reset_req: got %b want 0", req_o[2]); end
    nvec++; if (vld_o[2] !== 1'b0)           begin nerr++; $display("FAIL mid_reset_vld: got %b want 0", vld_o[2]); end
    nvec++; if (pc_o[2] !== 32'hFFFF_FFFC)   begin nerr++; $display("FAIL mid_reset_pc: got %h want fffffffc", pc_o[2]); end
    nvec++; if (ret_o[2] !== 32'd0)          begin nerr++; $display("FAIL mid_reset_retired: got %h want 0", ret_o[2]); end
    nvec++; if (instr_o[2] === 32'hDEAD_BEEF) begin nerr++; $display("FAIL mid_reset_instr: got %h want not deadbeef", instr_o[2]); end
    @(negedge clk);
    nvec++; if (req_o[2] !== 1'b1)           begin nerr++; $display("FAIL post_reset_req: got %b want 1", req_o[2]); end
    nvec++; if (addr_o[2] !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL post_reset_addr: got %h want fffffffc", addr_o[2]); end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst[0] = 1'b1; rst[1] = 1'b1; rst[2] = 1'b1;
    ack = 1'b0; rdata = 32'd0;
    branch = 1'b0; jump = 1'b0; alu_zero = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    test_first_fetch();
    test_ack_wait();
    test_branch();
    test_stall();
    test_jump();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
